// File: rtl/ram_arb.sv
// Shared byte-enabled word RAM with CH round-robin request channels and one access per cycle.
// Define RAM_ARB_OUT_REG_EN to add an output register after extraction (latency N+2).
module ram_arb #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2048,
   parameter int CH    = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [CH-1:0]       req_valid_i,
   output logic [CH-1:0]       req_ready_o,
   input  logic [CH-1:0]       req_we_i,
   input  logic [2*CH-1:0]     req_size_i,
   input  logic [CH-1:0]       req_unsigned_i,
   input  logic [XLEN*CH-1:0]  req_addr_i,
   input  logic [XLEN*CH-1:0]  req_wdata_i,
   output logic [CH-1:0]       rsp_valid_o,
   output logic [XLEN*CH-1:0]  rsp_data_o,
   output logic [CH-1:0]       rsp_err_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = (CH > 1) ? $clog2(CH) : 1;

   logic [CW-1:0]    rr_q, rr_d;
   logic [CH-1:0]    grant;
   logic [CW-1:0]    gnt_idx;
   logic             found;
   logic [CW:0]      sum;
   logic             accepted;
   logic             sel_we, sel_unsigned, sel_err;
   logic [1:0]       sel_size, lane;
   logic [XLEN-1:0]  sel_addr, sel_wdata;
   logic [AW-1:0]    word_idx;
   logic [3:0]       be_d;
   logic [XLEN-1:0]  wdata_d;
   logic             mem_we, rd_en;

   logic             s1_valid_q, s1_valid_d, s1_we_q, s1_we_d, s1_err_q, s1_err_d;
   logic             s1_unsigned_q, s1_unsigned_d;
   logic [1:0]       s1_size_q, s1_size_d, s1_lane_q, s1_lane_d;
   logic [CW-1:0]    s1_ch_q, s1_ch_d;
   logic [XLEN-1:0]  rd_word_q, shifted, ext;

   logic [CH-1:0]       rsp_valid_d, rsp_err_d;
   logic [XLEN*CH-1:0]  rsp_data_d;

   logic [XLEN-1:0]  mem [DEPTH];

   // Round-robin search starting at rr_q, wrapping modulo CH; first asserted valid wins.
   always_comb begin
      grant   = '0;
      gnt_idx = '0;
      found   = 1'b0;
      sum     = '0;
      for (int i = 0; i < CH; i++) begin
         sum = {1'b0, rr_q} + (CW+1)'(i);
         if (sum >= (CW+1)'(CH)) sum = sum - (CW+1)'(CH);
         if (!found && req_valid_i[sum[CW-1:0]]) begin
            grant[sum[CW-1:0]] = 1'b1;
            gnt_idx            = sum[CW-1:0];
            found              = 1'b1;
         end
      end
   end

   assign req_ready_o = grant;
   assign accepted    = found;

   always_comb begin
      sel_we       = req_we_i[gnt_idx];
      sel_unsigned = req_unsigned_i[gnt_idx];
      sel_size     = req_size_i[gnt_idx*2 +: 2];
      sel_addr     = req_addr_i[gnt_idx*XLEN +: XLEN];
      sel_wdata    = req_wdata_i[gnt_idx*XLEN +: XLEN];
      lane         = sel_addr[1:0];
      word_idx     = sel_addr[AW+1:2];
      sel_err      = (sel_size == 2'b11) ||
                     (sel_size == 2'b01 && sel_addr[0]) ||
                     (sel_size == 2'b10 && sel_addr[1:0] != 2'b00) ||
                     (sel_addr[XLEN-1:2] >= (XLEN-2)'(DEPTH));
      case (sel_size)
         2'b00:   begin be_d = 4'b0001 << lane; wdata_d = {4{sel_wdata[7:0]}};  end
         2'b01:   begin be_d = 4'b0011 << lane; wdata_d = {2{sel_wdata[15:0]}}; end
         default: begin be_d = 4'hF;            wdata_d = sel_wdata;            end
      endcase
      mem_we = accepted && sel_we && !sel_err;
      rd_en  = accepted && !sel_we && !sel_err;
   end

   always_comb begin
      rr_d = rr_q;
      if (accepted) rr_d = (gnt_idx == CW'(CH-1)) ? '0 : gnt_idx + 1'b1;
      s1_valid_d    = accepted;
      s1_we_d       = sel_we;
      s1_err_d      = sel_err;
      s1_unsigned_d = sel_unsigned;
      s1_size_d     = sel_size;
      s1_lane_d     = lane;
      s1_ch_d       = gnt_idx;
   end

   // Memory is never reset, so a write accepted alongside rst_i still lands.
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (be_d[b]) mem[word_idx][b*8 +: 8] <= wdata_d[b*8 +: 8];
         end
      end
      if (rd_en) rd_word_q <= mem[word_idx];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_q          <= '0;
         s1_valid_q    <= 1'b0;
         s1_we_q       <= 1'b0;
         s1_err_q      <= 1'b0;
         s1_unsigned_q <= 1'b0;
         s1_size_q     <= '0;
         s1_lane_q     <= '0;
         s1_ch_q       <= '0;
      end else begin
         rr_q          <= rr_d;
         s1_valid_q    <= s1_valid_d;
         s1_we_q       <= s1_we_d;
         s1_err_q      <= s1_err_d;
         s1_unsigned_q <= s1_unsigned_d;
         s1_size_q     <= s1_size_d;
         s1_lane_q     <= s1_lane_d;
         s1_ch_q       <= s1_ch_d;
      end
   end

   // Response stage; masked while rst_i is high so an in-flight response is dropped.
   always_comb begin
      shifted = rd_word_q >> {s1_lane_q, 3'b000};
      case (s1_size_q)
         2'b00:   ext = s1_unsigned_q ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
         2'b01:   ext = s1_unsigned_q ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
         default: ext = rd_word_q;
      endcase
      if (s1_we_q || s1_err_q) ext = '0;
      rsp_valid_d = '0;
      rsp_err_d   = '0;
      rsp_data_d  = '0;
      if (s1_valid_q && !rst_i) begin
         rsp_valid_d[s1_ch_q]              = 1'b1;
         rsp_err_d[s1_ch_q]                = s1_err_q;
         rsp_data_d[s1_ch_q*XLEN +: XLEN]  = ext;
      end
   end

`ifdef RAM_ARB_OUT_REG_EN
   logic [CH-1:0]       rsp_valid_q, rsp_err_q;
   logic [XLEN*CH-1:0]  rsp_data_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rsp_valid_q <= '0;
         rsp_err_q   <= '0;
         rsp_data_q  <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_err_o   = rsp_err_q;
   assign rsp_data_o  = rsp_data_q;
`else
   assign rsp_valid_o = rsp_valid_d;
   assign rsp_err_o   = rsp_err_d;
   assign rsp_data_o  = rsp_data_d;
`endif

endmodule

// File: tb/tb_ram_arb.sv
// Directed testbench for ram_arb: reset, sized reads/writes, round-robin, errors, mid-op reset.
module tb_ram_arb;
   localparam int CH = 2;
`ifdef RAM_ARB_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [CH-1:0] req_valid = '0, req_ready, req_we = '0, req_unsigned = '0;
   logic [2*CH-1:0]  req_size = '0;
   logic [32*CH-1:0] req_addr = '0, req_wdata = '0, rsp_data;
   logic [CH-1:0] rsp_valid, rsp_err;

   int nvec = 0;
   int nfail = 0;

   ram_arb #(.XLEN(32), .DEPTH(2048), .CH(CH)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
      .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
      .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
      .rsp_err_o(rsp_err)
   );

   always #5 clk = ~clk;

   // Single access on one channel; called and returns at posedge+1.
   task automatic access(input int ch, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic rdy, output logic [1:0] rv, output logic [31:0] rd,
                         output logic [1:0] re, output logic [1:0] rv2);
      req_valid = '0;
      req_valid[ch] = 1'b1;
      req_we[ch] = we;
      req_size[ch*2 +: 2] = size;
      req_unsigned[ch] = uns;
      req_addr[ch*32 +: 32] = addr;
      req_wdata[ch*32 +: 32] = wd;
      #1 rdy = req_ready[ch];
      @(posedge clk); #1 req_valid = '0;
      repeat (LAT-1) @(posedge clk);
      @(negedge clk);
      rv = rsp_valid; rd = rsp_data[ch*32 +: 32]; re = rsp_err;
      @(negedge clk);
      rv2 = rsp_valid;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      nvec++; if (rsp_valid !== 2'b00) begin nfail++; $display("[TB] FAIL reset_valid: got %b expected 00", rsp_valid); end
      nvec++; if (rsp_data !== 64'h0) begin nfail++; $display("[TB] FAIL reset_data: got %h expected 0", rsp_data); end
      nvec++; if (rsp_err !== 2'b00) begin nfail++; $display("[TB] FAIL reset_err: got %b expected 00", rsp_err); end
      nvec++; if (req_ready !== 2'b00) begin nfail++; $display("[TB] FAIL reset_ready: got %b expected 00", req_ready); end
      @(posedge clk); #1 rst = 1'b0;
   endtask

   task automatic test_write_read();
      logic rdy; logic [1:0] rv, re, rv2; logic [31:0] rd;
      access(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rdy, rv, rd, re, rv2);
      nvec++; if (rdy !== 1'b1) begin nfail++; $display("[TB] FAIL wr_ready: got %b expected 1", rdy); end
      nvec++; if (rv !== 2'b01) begin nfail++; $display("[TB] FAIL wr_rsp_valid: got %b expected 01", rv); end
      nvec++; if (rd !== 32'h0) begin nfail++; $display("[TB] FAIL wr_rsp_data: got %h expected 0", rd); end
      nvec++; if (rv2 !== 2'b00) begin nfail++; $display("[TB] FAIL wr_pulse: got %b expected 00", rv2); end
      access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rdy, rv, rd, re, rv2);
      nvec++; if (rv !== 2'b01) begin nfail++; $display("[TB] FAIL rd_rsp_valid: got %b expected 01", rv); end
      nvec++; if (rd !== 32'hDEADBEEF) begin nfail++; $display("[TB] FAIL rd_word: got %h expected deadbeef", rd); end
      nvec++; if (re !== 2'b00) begin nfail++; $display("[TB] FAIL rd_err: got %b expected 00", re); end
      nvec++; if (rv2 !== 2'b00) begin nfail++; $display("[TB] FAIL rd_pulse: got %b expected 00", rv2); end
   endtask

   task automatic test_sized_reads();
      logic rdy; logic [1:0] rv, re, rv2; logic [31:0] rd;
      logic [31:0] exp_b [4] = '{32'hFFFFFFEF, 32'hFFFFFFBE, 32'hFFFFFFAD, 32'hFFFFFFDE};
      for (int i = 0; i < 4; i++) begin
         access(0, 1'b0, 2'b00, 1'b0, 32'h10 + i, 32'h0, rdy, rv, rd, re, rv2);
         nvec++; if (rd !== exp_b[i]) begin nfail++; $display("[TB] FAIL byte_s%0d: got %h expected %h", i, rd, exp_b[i]); end
      end
      access(0, 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, rdy, rv, rd, re, rv2);
      nvec++; if (rd !== 32'h000000EF) begin nfail++; $display("[TB] FAIL byte_u: got %h expected 000000ef", rd); end
      access(0, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, rdy, rv, rd, re, rv2);
      nvec++; if (rd !== 32'h0000DEAD) begin nfail++; $display("[TB] FAIL half_u: got %h expected 0000dead", rd); end
      access(0, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, rdy, rv, rd, re, rv2);
      nvec++; if (rd !== 32'hFFFFDEAD) begin nfail++; $display("[TB] FAIL half_s: got %h expected ffffdead", rd); end
   endtask

   task automatic test_write_lanes();
      logic rdy; logic [1:0] rv, re, rv2; logic [31:0] rd;
      access(0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h000000A5, rdy, rv, rd, re, rv2);
      access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rdy, rv, rd, re, rv2);
      nvec++; if (rd !== 32'hDEADA5EF) begin nfail++; $display("[TB] FAIL byte_wr: got %h expected deada5ef", rd); end
      access(0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234, rdy, rv, rd, re, rv2);
      access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rdy, rv, rd, re, rv2);
      nvec++; if (rd !== 32'h1234A5EF) begin nfail++; $display("[TB] FAIL half_wr: got %h expected 1234a5ef", rd); end
   endtask

   task automatic test_round_robin();
      logic rdy; logic [1:0] rv, re, rv2; logic [31:0] rd;
      logic [1:0] exp_rdy, exp_rv;
      logic [31:0] exp_d;
      int c, cnt0, cnt1;
      cnt0 = 0; cnt1 = 0;
      access(1, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, rdy, rv, rd, re, rv2);
      nvec++; if (rv !== 2'b10) begin nfail++; $display("[TB] FAIL ch1_wr_valid: got %b expected 10", rv); end
      req_we = 2'b00; req_size = 4'b1010; req_unsigned = 2'b00;
      req_addr = {32'h20, 32'h10};
      req_valid = 2'b11;
      for (int i = 0; i < 6 + LAT; i++) begin
         @(negedge clk);
         if (i < 6) begin
            exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
            nvec++; if (req_ready !== exp_rdy) begin nfail++; $display("[TB] FAIL rr_grant%0d: got %b expected %b", i, req_ready, exp_rdy); end
         end
         if (i >= LAT) begin
            c = (i - LAT) % 2;
            exp_rv = (c == 0) ? 2'b01 : 2'b10;
            exp_d  = (c == 0) ? 32'h1234A5EF : 32'hCAFEF00D;
            if (rsp_valid[0]) cnt0++;
            if (rsp_valid[1]) cnt1++;
            nvec++; if (rsp_valid !== exp_rv) begin nfail++; $display("[TB] FAIL rr_rsp%0d: got %b expected %b", i, rsp_valid, exp_rv); end
            nvec++; if (rsp_data[c*32 +: 32] !== exp_d) begin nfail++; $display("[TB] FAIL rr_data%0d: got %h expected %h", i, rsp_data[c*32 +: 32], exp_d); end
            nvec++; if (rsp_data[(1-c)*32 +: 32] !== 32'h0) begin nfail++; $display("[TB] FAIL rr_idle_data%0d: got %h expected 0", i, rsp_data[(1-c)*32 +: 32]); end
         end else begin
            nvec++; if (rsp_valid !== 2'b00) begin nfail++; $display("[TB] FAIL rr_early%0d: got %b expected 00", i, rsp_valid); end
         end
         @(posedge clk); #1;
         if (i == 5) req_valid = '0;
      end
      nvec++; if (cnt0 !== 3) begin nfail++; $display("[TB] FAIL rr_cnt0: got %0d expected 3", cnt0); end
      nvec++; if (cnt1 !== 3) begin nfail++; $display("[TB] FAIL rr_cnt1: got %0d expected 3", cnt1); end
   endtask

   task automatic test_errors();
      logic rdy; logic [1:0] rv, re, rv2; logic [31:0] rd;
      access(0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h11223344, rdy, rv, rd, re, rv2);
      access(0, 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, rdy, rv, rd, re, rv2);
      nvec++; if (re !== 2'b01) begin nfail++; $display("[TB] FAIL half_mis_err: got %b expected 01", re); end
      nvec++; if (rd !== 32'h0) begin nfail++; $display("[TB] FAIL half_mis_data: got %h expected 0", rd); end
      nvec++; if (rv !== 2'b01) begin nfail++; $display("[TB] FAIL half_mis_valid: got %b expected 01", rv); end
      access(0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, rdy, rv, rd, re, rv2);
      nvec++; if (re !== 2'b01) begin nfail++; $display("[TB] FAIL size11_err: got %b expected 01", re); end
      access(0, 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, rdy, rv, rd, re, rv2);
      nvec++; if (re !== 2'b01) begin nfail++; $display("[TB] FAIL word_mis_err: got %b expected 01", re); end
      access(0, 1'b1, 2'b10, 1'b0, 32'h2000, 32'hFFFFFFFF, rdy, rv, rd, re, rv2);
      nvec++; if (re !== 2'b01) begin nfail++; $display("[TB] FAIL range_err: got %b expected 01", re); end
      access(0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rdy, rv, rd, re, rv2);
      nvec++; if (rd !== 32'h11223344) begin nfail++; $display("[TB] FAIL range_nowrite: got %h expected 11223344", rd); end
      nvec++; if (re !== 2'b00) begin nfail++; $display("[TB] FAIL range_read_err: got %b expected 00", re); end
   endtask

   task automatic test_reset_mid();
      req_valid = 2'b01; req_we[0] = 1'b0; req_size[1:0] = 2'b10; req_addr[31:0] = 32'h10;
      @(posedge clk); #1;
      req_valid = 2'b10; req_we[1] = 1'b1; req_size[3:2] = 2'b10;
      req_addr[63:32] = 32'h30; req_wdata[63:32] = 32'h5A5A5A5A;
      rst = 1'b1;
      @(negedge clk);
      nvec++; if (rsp_valid !== 2'b00) begin nfail++; $display("[TB] FAIL mid_drop: got %b expected 00", rsp_valid); end
      nvec++; if (req_ready !== 2'b10) begin nfail++; $display("[TB] FAIL mid_wr_grant: got %b expected 10", req_ready); end
      @(posedge clk); #1;
      rst = 1'b0;
      req_we = 2'b00; req_addr = {32'h20, 32'h30}; req_valid = 2'b11;
      @(negedge clk);
      nvec++; if (rsp_valid !== 2'b00) begin nfail++; $display("[TB] FAIL mid_drop2: got %b expected 00", rsp_valid); end
      nvec++; if (req_ready !== 2'b01) begin nfail++; $display("[TB] FAIL mid_rr0: got %b expected 01", req_ready); end
      @(posedge clk); #1 req_valid = '0;
      repeat (LAT-1) @(posedge clk);
      @(negedge clk);
      nvec++; if (rsp_valid !== 2'b01) begin nfail++; $display("[TB] FAIL mid_rsp: got %b expected 01", rsp_valid); end
      nvec++; if (rsp_data[31:0] !== 32'h5A5A5A5A) begin nfail++; $display("[TB] FAIL mid_commit: got %h expected 5a5a5a5a", rsp_data[31:0]); end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_sized_reads();
      test_write_lanes();
      test_round_robin();
      test_errors();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
